// File: rtl/note_sequencer.sv
// note_sequencer: 16-step (note, duration) pattern player for one tone voice.
// Walks the pattern table under a tick timebase. Each step sounds a gated
// square wave at the step's pitch for its duration, followed by a fixed
// silent gap. A duration of 0 marks the end of the pattern.
//
// Control handshake: start/stop/wr_en are single-cycle level samples, not
// valid/ready pairs. start is taken only while idle. stop wins over
// everything, including a simultaneous start. done is a one-cycle pulse
// that is raised only on natural completion, never on stop.
module note_sequencer #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int GAP_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic        busy,
  output logic [3:0]  step_idx,
  output logic [3:0]  note,
  output logic        gate,
  output logic        tone_out,
  output logic        done,
  output logic [1:0]  dbgState
);

  localparam int          TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [11:0] patTable [16];
  logic [1:0]  state;
  logic [7:0]  durReg;
  logic [31:0] prescaler;
  logic [31:0] tickCnt;
  logic [31:0] halfCnt;
  logic [31:0] halfPeriod;
  logic        toneReg;

  logic        pitched;
  logic        tickEnd;
  logic        noteEnd;
  logic        gapEnd;
  logic [3:0]  nextIdx;
  logic        candOk;
  logic        entry0Ok;
  logic        fetchGo;
  logic [3:0]  fetchIdx;
  logic [11:0] fetchEntry;

  // Pattern table: cleared by reset, writable in any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) patTable[i] <= 12'd0;
    end else if (wr_en) begin
      patTable[wr_addr] <= wr_data;
    end
  end

  // Half-period lookup for the latched note code; codes outside 1..8 are rests.
  always_comb begin
    halfPeriod = 32'd0;
    case (note)
      4'd1: halfPeriod = 32'(CLK_HZ / (2 * 392));
      4'd2: halfPeriod = 32'(CLK_HZ / (2 * 440));
      4'd3: halfPeriod = 32'(CLK_HZ / (2 * 494));
      4'd4: halfPeriod = 32'(CLK_HZ / (2 * 523));
      4'd5: halfPeriod = 32'(CLK_HZ / (2 * 587));
      4'd6: halfPeriod = 32'(CLK_HZ / (2 * 659));
      4'd7: halfPeriod = 32'(CLK_HZ / (2 * 698));
      4'd8: halfPeriod = 32'(CLK_HZ / (2 * 784));
      default: halfPeriod = 32'd0;
    endcase
  end

  // End-of-interval detection and the combinational fetch of the next step.
  // From IDLE the fetch is always entry 0; from the last GAP cycle it is the
  // following entry, falling back to entry 0 (loop) or to finish.
  always_comb begin
    pitched  = (note >= 4'd1) && (note <= 4'd8);
    tickEnd  = (prescaler == TICK_LAST);
    noteEnd  = (state == NOTE) && tickEnd && (tickCnt == (32'(durReg) - 32'd1));
    gapEnd   = (state == GAP) && tickEnd && (tickCnt == GAP_LAST);
    nextIdx  = step_idx + 4'd1;
    candOk   = (step_idx != 4'd15) && (patTable[nextIdx][7:0] != 8'd0);
    entry0Ok = (patTable[0][7:0] != 8'd0);
    fetchGo  = 1'b0;
    fetchIdx = 4'd0;
    if (state == IDLE) begin
      fetchGo = entry0Ok;
    end else if (candOk) begin
      fetchGo  = 1'b1;
      fetchIdx = nextIdx;
    end else begin
      fetchGo = loop_en && entry0Ok;
    end
    fetchEntry = patTable[fetchIdx];
  end

  // Sequencer FSM with tick prescaler, duration counter and tone generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step_idx  <= 4'd0;
      note      <= 4'd0;
      durReg    <= 8'd0;
      prescaler <= 32'd0;
      tickCnt   <= 32'd0;
      halfCnt   <= 32'd0;
      toneReg   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        toneReg <= 1'b0;
      end else if (((state == IDLE) && start) || gapEnd) begin
        if (fetchGo) begin
          state     <= NOTE;
          step_idx  <= fetchIdx;
          note      <= fetchEntry[11:8];
          durReg    <= fetchEntry[7:0];
          prescaler <= 32'd0;
          tickCnt   <= 32'd0;
          halfCnt   <= 32'd0;
          toneReg   <= 1'b0;
        end else begin
          state   <= IDLE;
          done    <= 1'b1;
          toneReg <= 1'b0;
        end
      end else if (state != IDLE) begin
        prescaler <= tickEnd ? 32'd0 : prescaler + 32'd1;
        if (tickEnd) tickCnt <= tickCnt + 32'd1;
        if (noteEnd) begin
          state     <= GAP;
          prescaler <= 32'd0;
          tickCnt   <= 32'd0;
          toneReg   <= 1'b0;
        end else if ((state == NOTE) && pitched) begin
          if (halfCnt == (halfPeriod - 32'd1)) begin
            halfCnt <= 32'd0;
            toneReg <= ~toneReg;
          end else begin
            halfCnt <= halfCnt + 32'd1;
          end
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign gate     = (state == NOTE) && pitched;
  assign tone_out = toneReg & gate;
  assign dbgState = state;

endmodule
